// File: rtl/spi_slave_rx.sv
// SPI responder: oversamples sclk/cs/mosi in i_clk, receives one word per frame, returns i_tx_data on MISO.
// Optional frame-length checking in END is compiled in with `define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_rx #(
  parameter int   DATA_WIDTH = 24,
  parameter logic CPOL       = 1'b1,
  parameter logic CPHA       = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_fRST,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic                  o_busy,
  output logic                  o_frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_END    = 2'd2
  } state_t;

  // bit0/bit1 form the synchroniser, bit2 is the previous synchronised value
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  valid_pend_q, valid_pend_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic                  first_lead_q, first_lead_d;
  logic [1:0]            fill_q, fill_d;
  logic                  armed_q, armed_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                  frame_err_q, frame_err_d;
`endif

  logic leading_edge, trailing_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, mosi_s;
  logic [DATA_WIDTH-1:0] rx_shifted;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[1:0], cs};
    mosi_sync_d = {mosi_sync_q[0], mosi};

    leading_edge  = (sclk_sync_q[1] != CPOL) && (sclk_sync_q[2] == CPOL);
    trailing_edge = (sclk_sync_q[1] == CPOL) && (sclk_sync_q[2] != CPOL);
    sample_edge   = CPHA ? trailing_edge : leading_edge;
    shift_edge    = CPHA ? leading_edge : trailing_edge;
    cs_fall       = !cs_sync_q[1] && cs_sync_q[2];
    cs_rise       = cs_sync_q[1] && !cs_sync_q[2];
    mosi_s        = mosi_sync_q[1];
    rx_shifted    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  end

  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    bit_cnt_d    = bit_cnt_q;
    valid_pend_d = 1'b0;
    first_lead_d = first_lead_q;
    rx_valid_d   = valid_pend_q;
    miso_d       = (state_q == ST_ACTIVE) ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
    miso_oe_d    = (state_q == ST_ACTIVE);
    fill_d       = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    // A frame may only start after CS has been seen high with real pin data
    // in the synchroniser, so a CS held low through reset cannot start one.
    armed_d      = armed_q || ((fill_q == 2'd2) && cs_sync_q[1]);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          tx_shift_d   = i_tx_data;
          rx_shift_d   = '0;
          bit_cnt_d    = '0;
          first_lead_d = 1'b1;
          state_d      = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (sample_edge) begin
          rx_shift_d = rx_shifted;
          if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (bit_cnt_q == CNT_LAST) begin
            rx_data_d    = rx_shifted;
            valid_pend_d = 1'b1;
          end
        end
        // With CPHA=1 the MSB is presented at CS fall, so the first leading edge must not shift.
        if (shift_edge && !(CPHA && first_lead_q)) begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (leading_edge) begin
          first_lead_d = 1'b0;
        end
        if (cs_rise) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = (bit_cnt_q != CNT_FULL);
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_fRST) begin
      sclk_sync_q  <= {3{CPOL}};
      cs_sync_q    <= 3'b111;
      mosi_sync_q  <= 2'b00;
      state_q      <= ST_IDLE;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      bit_cnt_q    <= '0;
      valid_pend_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      first_lead_q <= 1'b0;
      fill_q       <= 2'd0;
      armed_q      <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      bit_cnt_q    <= bit_cnt_d;
      valid_pend_q <= valid_pend_d;
      rx_valid_q   <= rx_valid_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      first_lead_q <= first_lead_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q  <= frame_err_d;
`endif
    end
  end

  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_miso     = miso_q;
  assign o_miso_oe  = miso_oe_q;
  assign o_busy     = (state_q != ST_IDLE);
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign o_frame_err = frame_err_q;
`else
  assign o_frame_err = 1'b0;
`endif

endmodule
